// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the single-port 256x32 data memory.
// Port 0 is the MEM stage, port 1 the loader/debug port; port 1 is protected from starvation.
module dmem_arbiter #(
    parameter int unsigned ADDR_LIMIT = 1024,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,

    output logic        MemWrite,
    output logic        MemRead,
    output logic [31:0] Address,
    output logic [31:0] Write_data,
    input  logic [31:0] Read_data
);

    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [31:0] ADDR_LIM   = 32'(ADDR_LIMIT);

    logic [3:0]  starve_cnt;
    logic        any_gnt;
    logic        sel_we;
    logic        fault;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    // Port 1 wins when alone or once it has waited STARVE_MAX cycles in a row.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst) begin
            if (p1_req && (!p0_req || starve_cnt == STARVE_LIM))
                p1_gnt = 1'b1;
            else if (p0_req)
                p0_gnt = 1'b1;
        end
    end

    assign any_gnt   = p0_gnt | p1_gnt;
    assign sel_we    = p1_gnt ? p1_we    : p0_we;
    assign sel_addr  = p1_gnt ? p1_addr  : p0_addr;
    assign sel_wdata = p1_gnt ? p1_wdata : p0_wdata;
    assign fault     = (sel_addr[1:0] != 2'b00) || (sel_addr >= ADDR_LIM);

    // A faulted grant is consumed but never reaches the memory strobes.
    assign MemWrite   = any_gnt && !fault &&  sel_we;
    assign MemRead    = any_gnt && !fault && !sel_we;
    assign Address    = any_gnt ? sel_addr  : 32'd0;
    assign Write_data = any_gnt ? sel_wdata : 32'd0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_rvalid  <= 1'b0;
            p0_err     <= 1'b0;
            p0_rdata   <= 32'd0;
            p1_rvalid  <= 1'b0;
            p1_err     <= 1'b0;
            p1_rdata   <= 32'd0;
            starve_cnt <= 4'd0;
        end else begin
            p0_rvalid <= p0_gnt && !p0_we;
            p0_err    <= p0_gnt && fault;
            if (p0_gnt && !p0_we)
                p0_rdata <= fault ? 32'd0 : Read_data;

            p1_rvalid <= p1_gnt && !p1_we;
            p1_err    <= p1_gnt && fault;
            if (p1_gnt && !p1_we)
                p1_rdata <= fault ? 32'd0 : Read_data;

            if (!p1_req || p1_gnt)
                starve_cnt <= 4'd0;
            else if (starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: reference memory plus arbitration model feeding a
// response scoreboard, with a behavioural 256x32 memory attached to the strobes.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_LIMIT = 1024;
    localparam int unsigned STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        MemWrite, MemRead;
    logic [31:0] Address, Write_data, Read_data;

    dmem_arbiter #(.ADDR_LIMIT(ADDR_LIMIT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .MemWrite(MemWrite), .MemRead(MemRead), .Address(Address),
        .Write_data(Write_data), .Read_data(Read_data)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory driven by the arbiter.
    logic [31:0] env_mem [256];
    assign Read_data = env_mem[Address[9:2]];
    always @(posedge clk) if (MemWrite) env_mem[Address[9:2]] <= Write_data;

    typedef struct {
        int          port;
        logic        rvalid;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] ref_mem [256];
    logic [31:0] last_rdata [2];
    int          m_starve;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        obs_g1;

    function automatic logic [31:0] init_word(input int i);
        return 32'hA500_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One clock cycle: drive at negedge, check strobes, predict responses, check them after posedge.
    task automatic step(input string tag,
                        input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        logic        m_g0, m_g1, m_any, m_we, m_f, g, we;
        logic [31:0] m_a, m_d;
        exp_t        e;
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        #1;
        m_g1  = !rst && r1 && (!r0 || m_starve == int'(STARVE_MAX));
        m_g0  = !rst && r0 && !m_g1;
        m_any = m_g0 || m_g1;
        m_a   = m_g1 ? a1 : a0;
        m_d   = m_g1 ? d1 : d0;
        m_we  = m_g1 ? w1 : w0;
        m_f   = (m_a[1:0] != 2'b00) || (m_a >= ADDR_LIMIT);
        check($sformatf("%s_gnt", tag), {30'd0, p1_gnt, p0_gnt}, {30'd0, m_g1, m_g0});
        check($sformatf("%s_memrd", tag), 32'(MemRead), 32'(m_any && !m_f && !m_we));
        check($sformatf("%s_memwr", tag), 32'(MemWrite), 32'(m_any && !m_f && m_we));
        check($sformatf("%s_addr", tag), Address, m_any ? m_a : 32'd0);
        obs_g1 = p1_gnt;

        for (int p = 0; p < 2; p++) begin
            g  = (p == 1) ? m_g1 : m_g0;
            we = (p == 1) ? w1 : w0;
            e.port = p;
            if (rst) begin
                last_rdata[p] = 32'd0;
                e.rvalid = 1'b0;
                e.err    = 1'b0;
            end else begin
                e.rvalid = g && !we;
                e.err    = g && m_f;
                if (g && !we) last_rdata[p] = m_f ? 32'd0 : ref_mem[m_a[9:2]];
            end
            e.rdata = last_rdata[p];
            sb_q.push_back(e);
        end

        if (!rst && m_any && !m_f && m_we) ref_mem[m_a[9:2]] = m_d;
        if (rst || !r1 || m_g1) m_starve = 0;
        else if (m_starve < int'(STARVE_MAX)) m_starve++;

        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.port == 0) begin
                check($sformatf("%s_p0_rvalid", tag), 32'(p0_rvalid), 32'(e.rvalid));
                check($sformatf("%s_p0_err", tag), 32'(p0_err), 32'(e.err));
                check($sformatf("%s_p0_rdata", tag), p0_rdata, e.rdata);
            end else begin
                check($sformatf("%s_p1_rvalid", tag), 32'(p1_rvalid), 32'(e.rvalid));
                check($sformatf("%s_p1_err", tag), 32'(p1_err), 32'(e.err));
                check($sformatf("%s_p1_rdata", tag), p1_rdata, e.rdata);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i] <= init_word(i);
            ref_mem[i]  = init_word(i);
        end
        last_rdata[0] = 32'd0;
        last_rdata[1] = 32'd0;
        m_starve = 0;
        obs_g1   = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'd0; p0_wdata = 32'd0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'd0; p1_wdata = 32'd0;
        rst = 1'b1;
        @(negedge clk);

        // Request held across reset, then re-presented after release
        step("t1_rst", 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        step("t1_rst", 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b0;
        step("t1_go", 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("t1_rdata_const", p0_rdata, init_word(4));
        idle("t1_idle");

        // Write then read-after-write on port 0
        step("t2_wr", 1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0, 32'd0);
        step("t2_rd", 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("t2_rdata_const", p0_rdata, 32'hDEADBEEF);
        step("t2_b2b", 1'b1, 1'b0, 32'h24, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        step("t2_b2b", 1'b1, 1'b0, 32'h28, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        idle("t2_idle");

        // Continuous contention: p1 wins every fifth cycle
        for (int i = 0; i < 10; i++) begin
            check("t3_starve_cnt", 32'(dut.starve_cnt), 32'(i % 5));
            step("t3_both", 1'b1, 1'b0, 32'h30 + 32'(4 * (i % 3)), 32'd0,
                            1'b1, 1'b0, 32'h80 + 32'(4 * (i % 2)), 32'd0);
            check("t3_p1_pattern", 32'(obs_g1), 32'((i % 5) == 4));
        end
        idle("t3_idle");

        // Misaligned out-of-range read on port 1
        step("t4_p1_bad", 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h402, 32'd0);
        check("t4_p1_err_const", 32'(p1_err), 32'd1);
        check("t4_p1_rvalid_const", 32'(p1_rvalid), 32'd1);
        check("t4_p1_rdata_const", p1_rdata, 32'd0);
        idle("t4_idle");

        // Write at the address limit must not touch memory
        step("t5_wr_lim", 1'b1, 1'b1, 32'h400, 32'h12345678, 1'b0, 1'b0, 32'd0, 32'd0);
        check("t5_p0_err_const", 32'(p0_err), 32'd1);
        step("t5_rd0", 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("t5_rd0_const", p0_rdata, init_word(0));
        step("t5_wr_last", 1'b1, 1'b1, 32'h3FC, 32'hCAFEF00D, 1'b0, 1'b0, 32'd0, 32'd0);
        step("t5_rd_last", 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h3FC, 32'd0);
        check("t5_rd_last_const", p1_rdata, 32'hCAFEF00D);

        // Alternating p0 writes and p1 reads of the same words
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0)
                step("t6_p0_wr", 1'b1, 1'b1, 32'h40 + 32'(4 * (i / 2)), 32'h5A00_0000 + 32'(i),
                                 1'b0, 1'b0, 32'd0, 32'd0);
            else
                step("t6_p1_rd", 1'b0, 1'b0, 32'd0, 32'd0,
                                 1'b1, 1'b0, 32'h40 + 32'(4 * (i / 2)), 32'd0);
        end
        check("t6_last_const", p1_rdata, 32'h5A00_0006);
        step("t6_mix", 1'b1, 1'b1, 32'h3, 32'h1, 1'b1, 1'b0, 32'h44, 32'd0);
        step("t6_mix", 1'b1, 1'b0, 32'h44, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        idle("t6_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
